// File: rtl/cordic_pkg.sv
// arctan(2^-i) constant tables for the CORDIC sin(x) datapath.
// Tables are built at elaboration from exact fixed-point series sums.
package cordic_pkg;

    localparam int FMT_FLOAT = 0;
    localparam int FMT_Q230  = 1;
    localparam int FX        = 80;

    typedef logic [191:0]      wide_t;
    typedef logic [31:0][31:0] tab_t;

    // atan(1/m) as an FX-fraction-bit fixed-point value (Taylor series)
    function automatic wide_t atan_inv(input wide_t m);
        wide_t one;
        wide_t acc;
        wide_t pw;
        wide_t term;
        logic  live;
        one  = wide_t'(1) << FX;
        acc  = '0;
        pw   = m;
        live = 1'b1;
        for (int k = 0; k < 48; k++) begin
            if (live) begin
                term = one / pw / wide_t'(2 * k + 1);
                if (k[0]) acc = acc - term;
                else      acc = acc + term;
                pw = pw * m * m;
                if (pw > one) live = 1'b0;
            end
        end
        return acc;
    endfunction

    // pi/4 = atan(1/2) + atan(1/3) keeps the i = 0 series fast
    function automatic wide_t atan_fx(input int i);
        if (i == 0) return atan_inv(wide_t'(2)) + atan_inv(wide_t'(3));
        return atan_inv(wide_t'(1) << i);
    endfunction

    function automatic logic [31:0] fx_to_q230(input wide_t a);
        wide_t r;
        r = (a + (wide_t'(1) << (FX - 31))) >> (FX - 30);
        return r[31:0];
    endfunction

    function automatic logic [31:0] fx_to_float_deg(input wide_t a);
        wide_t d;
        wide_t pi_fx;
        wide_t mant;
        wide_t lo_mask;
        int    p;
        int    e;
        logic  g;
        logic  st;
        pi_fx = atan_fx(0) << 2;
        d     = ((a * wide_t'(180)) << FX) / pi_fx;
        p     = 0;
        for (int b = 0; b < 192; b++) begin
            if (d[8'(b)]) p = b;
        end
        mant    = d >> (p - 23);
        g       = d[8'(p - 24)];
        lo_mask = (wide_t'(1) << (p - 24)) - wide_t'(1);
        st      = |(d & lo_mask);
        if (g && (st || mant[0])) mant = mant + wide_t'(1);
        e = p - FX + 127;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        return {1'b0, e[7:0], mant[22:0]};
    endfunction

    function automatic tab_t build_tab(input int fmt);
        tab_t  t;
        wide_t a;
        for (int i = 0; i < 32; i++) begin
            a = atan_fx(i);
            t[5'(i)] = (fmt == FMT_Q230) ? fx_to_q230(a)
                                         : fx_to_float_deg(a);
        end
        return t;
    endfunction

    localparam tab_t ATAN_FLOAT = build_tab(FMT_FLOAT);
    localparam tab_t ATAN_Q230  = build_tab(FMT_Q230);

    function automatic logic [31:0] atan_word(input int fmt,
                                              input logic [4:0] idx);
        return (fmt == FMT_Q230) ? ATAN_Q230[idx] : ATAN_FLOAT[idx];
    endfunction

endpackage

// File: rtl/cordic_atan_seq.sv
// arctan table with a 1-cycle random read port and a
// valid/ready stream port that walks entries 0..n-1.
module cordic_atan_seq
    import cordic_pkg::*;
#(
    parameter int DEPTH  = 24,
    parameter int IDX_W  = 5,
    parameter int FMT    = 0,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    input  logic              start,
    input  logic [IDX_W:0]    count,
    output logic [DATA_W-1:0] s_data,
    output logic [IDX_W-1:0]  s_idx,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              s_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

    state_t            r_state;
    state_t            w_state;
    logic [IDX_W:0]    r_n;
    logic [IDX_W:0]    w_n;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] r_s_data;
    logic [DATA_W-1:0] w_s_data;
    logic              r_s_valid;
    logic              w_s_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_err;

    logic [31:0]       w_rd_ext;
    logic [31:0]       w_s_ext;
    logic              w_rd_oob;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_s_word;
    logic              w_last;

    assign w_rd_ext  = 32'(rd_idx);
    assign w_rd_oob  = w_rd_ext >= 32'(DEPTH);
    assign w_rd_word = w_rd_oob ? '0 : atan_word(FMT, w_rd_ext[4:0]);

    // stream lookup points at the word that will be shown next
    assign w_s_ext  = (r_state == STREAM) ? 32'(r_idx) + 32'd1 : 32'd0;
    assign w_s_word = atan_word(FMT, w_s_ext[4:0]);

    assign w_last = r_s_valid && ({1'b0, r_idx} == r_n - 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_err   <= rd_en & w_rd_oob;
            if (rd_en) r_rd_data <= w_rd_word;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_n       = r_n;
        w_idx     = r_idx;
        w_s_data  = r_s_data;
        w_s_valid = r_s_valid;
        unique case (r_state)
            IDLE: begin
                if (start && count != '0) begin
                    w_state = LOAD;
                    w_n     = (count > DEPTH_W) ? DEPTH_W : count;
                    w_idx   = '0;
                end
            end
            LOAD: begin
                w_s_data  = w_s_word;
                w_idx     = '0;
                w_s_valid = 1'b1;
                w_state   = STREAM;
            end
            STREAM: begin
                if (r_s_valid && s_ready) begin
                    if (w_last) begin
                        w_s_valid = 1'b0;
                        w_state   = IDLE;
                    end else begin
                        w_idx    = r_idx + 1'b1;
                        w_s_data = w_s_word;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_idx     <= '0;
            r_s_data  <= '0;
            r_s_valid <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_n       <= w_n;
            r_idx     <= w_idx;
            r_s_data  <= w_s_data;
            r_s_valid <= w_s_valid;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;
    assign s_data   = r_s_data;
    assign s_idx    = r_idx;
    assign s_valid  = r_s_valid;
    assign s_last   = w_last;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_cordic_atan_seq.sv
// Bench for cordic_atan_seq: float and Q2.30 instances share stimulus
// and are checked against real-math reference tables.
module tb_cordic_atan_seq;

    localparam int DEPTH = 24;
    localparam int IDX_W = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_idx = '0;
    logic        start = 1'b0;
    logic [5:0]  count = '0;
    logic        s_ready = 1'b0;

    logic [31:0] rd_data_f, rd_data_q, s_data_f, s_data_q;
    logic        rd_valid_f, rd_valid_q, rd_err_f, rd_err_q;
    logic [4:0]  s_idx_f, s_idx_q;
    logic        s_valid_f, s_valid_q, s_last_f, s_last_q;
    logic        busy_f, busy_q;
    logic [147:0] w_all;

    always #5 clk = ~clk;

    cordic_atan_seq #(.DEPTH(DEPTH), .IDX_W(IDX_W), .FMT(0), .DATA_W(32)) u_f (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_data(rd_data_f), .rd_valid(rd_valid_f), .rd_err(rd_err_f),
        .start(start), .count(count), .s_data(s_data_f), .s_idx(s_idx_f),
        .s_valid(s_valid_f), .s_ready(s_ready), .s_last(s_last_f),
        .busy(busy_f)
    );

    cordic_atan_seq #(.DEPTH(DEPTH), .IDX_W(IDX_W), .FMT(1), .DATA_W(32)) u_q (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_data(rd_data_q), .rd_valid(rd_valid_q), .rd_err(rd_err_q),
        .start(start), .count(count), .s_data(s_data_q), .s_idx(s_idx_q),
        .s_valid(s_valid_q), .s_ready(s_ready), .s_last(s_last_q),
        .busy(busy_q)
    );

    assign w_all = {rd_data_f, rd_valid_f, rd_err_f, s_data_f, s_idx_f,
                    s_valid_f, s_last_f, busy_f,
                    rd_data_q, rd_valid_q, rd_err_q, s_data_q, s_idx_q,
                    s_valid_q, s_last_q, busy_q};

    int checks = 0;
    int errors = 0;
    logic [31:0] rf [DEPTH];
    logic [31:0] rq [DEPTH];

    task automatic chk(input string tag, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] to_single(input real r);
        logic [63:0] b;
        logic [24:0] m;
        logic [7:0]  e;
        logic        g;
        logic        st;
        b  = $realtobits(r);
        e  = 8'(int'(b[62:52]) - 1023 + 127);
        m  = {2'b01, b[51:29]};
        g  = b[28];
        st = |b[27:0];
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 8'd1;
        end
        return {1'b0, e, m[22:0]};
    endfunction

    // random-access port: driver, edge capture and checker
    bit          rd_go = 1'b0;
    int          rd_k = 0;
    logic        p_en = 1'b0;
    logic        p_ok = 1'b0;
    logic [4:0]  p_idx = '0;
    logic [31:0] last_f, last_q;

    initial forever begin
        @(negedge clk);
        rd_en  = 1'($urandom_range(0, 1));
        rd_idx = 5'($urandom_range(0, 31));
        if (rd_go) begin
            if (rd_k < 4) rd_en = 1'b1;
            case (rd_k)
                0: rd_idx = 5'd0;
                1: rd_idx = 5'd25;
                2: rd_idx = 5'd23;
                3: rd_idx = 5'd24;
                default: ;
            endcase
            rd_k++;
        end
    end

    initial forever begin
        @(posedge clk);
        p_en  = rd_en;
        p_idx = rd_idx;
        p_ok  = reset;
    end

    initial begin
        logic [31:0] ef;
        logic [31:0] eq;
        last_f = '0;
        last_q = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_f = '0;
                last_q = '0;
            end else if (p_ok) begin
                chk("rd_valid", {rd_valid_f, rd_valid_q}, {p_en, p_en});
                if (p_en) begin
                    ef = (p_idx < DEPTH) ? rf[p_idx] : 32'd0;
                    eq = (p_idx < DEPTH) ? rq[p_idx] : 32'd0;
                    chk("rd_err", {rd_err_f, rd_err_q},
                        {2{p_idx >= 5'(DEPTH)}});
                    last_f = ef;
                    last_q = eq;
                end
                chk("rd_data", {rd_data_f, rd_data_q}, {last_f, last_q});
            end
        end
    end

    // mode 0: ready high, 1: random ready, 2: 4-cycle stall on word 1
    task automatic run_stream(input int cnt, input int mode, input bit inj);
        int n, k, busy_cyc, stall;
        bit done, exp_v;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        k = 0;
        busy_cyc = 0;
        stall = 0;
        done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        count = 6'(cnt);
        s_ready = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy_f) busy_cyc++;
            exp_v = (c >= 1) && (k < n);
            chk("s_valid", {s_valid_f, s_valid_q}, {2{exp_v}});
            chk("busy", {busy_f, busy_q}, {2{k < n}});
            if (exp_v) begin
                chk("s_idx", {s_idx_f, s_idx_q}, {2{5'(k)}});
                chk("s_data", {s_data_f, s_data_q}, {rf[k], rq[k]});
                chk("s_last", {s_last_f, s_last_q}, {2{k == n - 1}});
            end else begin
                chk("s_last_idle", {s_last_f, s_last_q}, 2'b00);
            end
            if (k == n) begin
                done = 1'b1;
            end else begin
                case (mode)
                    0: s_ready = 1'b1;
                    1: s_ready = 1'($urandom_range(0, 1));
                    default: begin
                        s_ready = !(exp_v && k == 1 && stall < 4);
                        if (!s_ready) stall++;
                    end
                endcase
                if (inj && stall == 2 && !s_ready) begin
                    start = 1'b1;
                    count = 6'd20;
                end
                if (exp_v && s_ready) k++;
            end
        end
        chk("stream_done", {31'd0, done}, 1);
        if (mode == 0) chk("stream_cycles", busy_cyc, n + 1);
        if (mode == 2) chk("stall_len", stall, 4);
    endtask

    initial begin
        real a;
        real pi;
        pi = 4.0 * $atan(1.0);
        for (int i = 0; i < DEPTH; i++) begin
            a = $atan($pow(2.0, -1.0 * i));
            rq[i] = 32'($rtoi(a * 1073741824.0 + 0.5));
            rf[i] = to_single(a * 180.0 / pi);
        end
        chk("ref_f0", rf[0], 32'h42340000);
        chk("ref_q1", rq[1], 32'h1DAC6705);

        #1 reset = 1'b0;
        #1 chk("reset_t0", w_all, '0);
        repeat (4) begin
            @(negedge clk);
            chk("reset_outs", w_all, '0);
            start   = 1'($urandom_range(0, 1));
            count   = 6'($urandom_range(0, 63));
            s_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        s_ready = 1'b0;
        reset = 1'b1;
        rd_go = 1'b1;

        run_stream(3, 0, 1'b0);
        run_stream(24, 1, 1'b0);
        run_stream(6, 2, 1'b1);

        @(negedge clk);
        start = 1'b1;
        count = 6'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("cnt0_idle", {busy_f, busy_q, s_valid_f, s_valid_q}, 4'h0);
        end

        @(negedge clk);
        start = 1'b1;
        count = 6'd10;
        s_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre", {busy_f, busy_q, s_valid_f, s_valid_q}, 4'hF);
        #2 reset = 1'b0;
        #1 chk("abort_outs", w_all, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        run_stream(31, 0, 1'b0);
        run_stream(17, 1, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
